// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone slave 8N1 UART transmitter fed by a byte FIFO.
// DATA (addr[0]=0) pushes bytes; STATUS (addr[0]=1) reports level, busy and sticky overflow.
module wb_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int LGFIFO       = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [29:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_uart_tx
);
    localparam int DEPTH = 1 << LGFIFO;
    localparam int CW = LGFIFO + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [7:0]        mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              ack_q;
    logic [31:0]       data_q, data_d;
    logic [31:0]       status;
    logic              req, wr_data, push, drop, rd_stat, pop, baud_last;
    logic              unused_bits;

    assign req       = i_wb_cyc && i_wb_stb;
    assign wr_data   = req && i_wb_we && !i_wb_addr[0] && i_wb_sel[0];
    assign push      = wr_data && (count_q < FULL_C);
    assign drop      = wr_data && (count_q == FULL_C);
    assign rd_stat   = req && !i_wb_we && i_wb_addr[0];
    assign baud_last = baud_q == BAUD_LAST;
    assign status    = {20'd0, ovf_q, state_q != IDLE, count_q == FULL_C, count_q == '0, 8'(count_q)};
    assign count_d   = count_q + CW'(push) - CW'(pop);
    // A drop in the same cycle as a STATUS read keeps the flag set.
    assign ovf_d     = drop || (ovf_q && !rd_stat);
    assign data_d    = rd_stat ? status : 32'd0;

    assign o_wb_ack    = ack_q;
    assign o_wb_stall  = 1'b0;
    assign o_wb_data   = data_q;
    assign o_uart_tx   = tx_q;
    assign unused_bits = ^{i_wb_addr[29:1], i_wb_data[31:8], i_wb_sel[3:1]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= push ? wr_ptr_q + LGFIFO'(1) : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + LGFIFO'(1) : rd_ptr_q;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ack_q    <= req;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= i_wb_data[7:0];
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        baud_d  = (state_q == IDLE || baud_last) ? '0 : baud_q + BW'(1);
        case (state_q)
            IDLE: if (count_q != '0) begin
                pop     = 1'b1;
                shift_d = mem[rd_ptr_q];
                state_d = START;
            end
            START: if (baud_last) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (baud_last) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (baud_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the next state so the register changes with the state.
    always_comb begin
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end
endmodule

// File: tb/tb_wb_uart_tx.sv
// tb_wb_uart_tx: randomized self-checking bench for wb_uart_tx (CLKS_PER_BIT=4, LGFIFO=2).
// A line monitor decodes frames at bit midpoints; expectations come from a byte queue model.
module tb_wb_uart_tx;
    localparam int CPB   = 4;
    localparam int LG    = 2;
    localparam int DEPTH = 1 << LG;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [29:0] addr_i = '0;
    logic [31:0] wdat_i = '0;
    logic [3:0]  sel_i = '0;
    logic        o_wb_ack, o_wb_stall, o_uart_tx;
    logic [31:0] o_wb_data;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [9:0]  rx_bits[$];
    int          rx_t[$];

    wb_uart_tx #(.CLKS_PER_BIT(CPB), .LGFIFO(LG)) dut (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc_i), .i_wb_stb(stb_i), .i_wb_we(we_i),
        .i_wb_addr(addr_i), .i_wb_data(wdat_i), .i_wb_sel(sel_i), .o_wb_ack(o_wb_ack),
        .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data), .o_uart_tx(o_uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: start edge seen at a negedge, then sample every CPB cycles from mid start bit.
    initial begin : monitor
        logic       prev;
        logic       ab;
        logic [9:0] v;
        int         t0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !o_uart_tx) begin
                t0 = cyc;
                ab = 1'b0;
                v  = '0;
                for (int j = 1; j <= FRAME - 2; j++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                    if (j % CPB == CPB / 2) v[j / CPB] = o_uart_tx;
                end
                if (!ab) begin
                    rx_bits.push_back(v);
                    rx_t.push_back(t0);
                end
            end
            prev = o_uart_tx;
        end
    end

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    function automatic logic [31:0] model_status(input int cnt, input bit busy, input bit ovf);
        return (32'(ovf) << 11) | (32'(busy) << 10) | (32'(cnt == DEPTH) << 9) | (32'(cnt == 0) << 8) | 32'(cnt);
    endfunction

    task automatic bus(input logic we, input logic a, input logic [31:0] d, input logic [3:0] sel,
                       output logic ack, output logic [31:0] rd);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; addr_i = {29'd0, a}; wdat_i = d; sel_i = sel;
        @(negedge clk);
        ack = o_wb_ack;
        rd  = o_wb_data;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; addr_i = '0; wdat_i = '0; sel_i = '0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int w = 0;
        while (rx_bits.size() < n && w < budget) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic test_reset;
        logic ack;
        logic [31:0] rd;
        repeat (3) @(negedge clk);
        total++; if (o_uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", o_uart_tx); end
        total++; if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", o_wb_ack); end
        total++; if (o_wb_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", o_wb_data); end
        total++; if (o_wb_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", o_wb_stall); end
        rst = 1'b0;
        @(negedge clk);
        bus(1'b0, 1'b1, 32'd0, 4'hF, ack, rd);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL reset_stat_ack got=%b exp=1", ack); end
        total++; if (rd !== model_status(0, 0, 0)) begin bad++; $display("FAIL reset_status got=%h exp=%h", rd, model_status(0, 0, 0)); end
        @(negedge clk);
        total++; if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL reset_ack_single got=%b exp=0", o_wb_ack); end
        total++; if (o_wb_data !== 32'd0) begin bad++; $display("FAIL reset_data_idle got=%h exp=0", o_wb_data); end
    endtask

    task automatic test_frame_a5;
        logic ack;
        logic [31:0] rd;
        int base = rx_bits.size();
        int c = cyc;
        bus(1'b1, 1'b0, 32'h1234_56A5, 4'h1, ack, rd);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL a5_ack got=%b exp=1", ack); end
        total++; if (o_uart_tx !== 1'b1) begin bad++; $display("FAIL a5_tx_n1 got=%b exp=1", o_uart_tx); end
        @(negedge clk);
        total++; if (o_uart_tx !== 1'b0) begin bad++; $display("FAIL a5_tx_n2 got=%b exp=0", o_uart_tx); end
        while (cyc < c + 12) @(negedge clk);
        bus(1'b0, 1'b1, 32'd0, 4'hF, ack, rd);
        total++; if (rd !== model_status(0, 1, 0)) begin bad++; $display("FAIL a5_busy got=%h exp=%h", rd, model_status(0, 1, 0)); end
        wait_frames(base + 1, 3 * FRAME);
        total++; if (rx_bits.size() !== base + 1) begin bad++; $display("FAIL a5_frames got=%0d exp=%0d", rx_bits.size(), base + 1); end
        if (rx_bits.size() > base) begin
            total++; if (rx_bits[base] !== frame_of(8'hA5)) begin bad++; $display("FAIL a5_bits got=%b exp=%b", rx_bits[base], frame_of(8'hA5)); end
            total++; if (rx_t[base] !== c + 2) begin bad++; $display("FAIL a5_start got=%0d exp=%0d", rx_t[base], c + 2); end
        end
        while (cyc < c + FRAME + 4) @(negedge clk);
        bus(1'b0, 1'b1, 32'd0, 4'hF, ack, rd);
        total++; if (rd !== model_status(0, 0, 0)) begin bad++; $display("FAIL a5_idle got=%h exp=%h", rd, model_status(0, 0, 0)); end
    endtask

    task automatic test_b2b_reads;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 30'd0;
        @(negedge clk);
        total++; if (o_wb_ack !== 1'b1) begin bad++; $display("FAIL rd_ack0 got=%b exp=1", o_wb_ack); end
        total++; if (o_wb_data !== 32'd0) begin bad++; $display("FAIL rd_data0 got=%h exp=0", o_wb_data); end
        total++; if (o_wb_stall !== 1'b0) begin bad++; $display("FAIL rd_stall0 got=%b exp=0", o_wb_stall); end
        addr_i = 30'd1;
        @(negedge clk);
        total++; if (o_wb_ack !== 1'b1) begin bad++; $display("FAIL rd_ack1 got=%b exp=1", o_wb_ack); end
        total++; if (o_wb_data !== model_status(0, 0, 0)) begin bad++; $display("FAIL rd_data1 got=%h exp=%h", o_wb_data, model_status(0, 0, 0)); end
        total++; if (o_wb_stall !== 1'b0) begin bad++; $display("FAIL rd_stall1 got=%b exp=0", o_wb_stall); end
        cyc_i = 1'b0; stb_i = 1'b0; addr_i = '0;
        @(negedge clk);
        total++; if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL rd_ack2 got=%b exp=0", o_wb_ack); end
        total++; if (o_wb_data !== 32'd0) begin bad++; $display("FAIL rd_data2 got=%h exp=0", o_wb_data); end
    endtask

    task automatic test_back_to_back;
        logic ack;
        logic [31:0] rd;
        logic [7:0] b[6];
        int base = rx_bits.size();
        int c = cyc;
        foreach (b[i]) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            bus(1'b1, 1'b0, {24'($urandom), b[i]}, 4'h1, ack, rd);
            total++; if (ack !== 1'b1) begin bad++; $display("FAIL b2b_ack%0d got=%b exp=1", i, ack); end
        end
        bus(1'b0, 1'b1, 32'd0, 4'hF, ack, rd);
        total++; if (rd !== model_status(DEPTH, 1, 1)) begin bad++; $display("FAIL b2b_status got=%h exp=%h", rd, model_status(DEPTH, 1, 1)); end
        @(negedge clk);
        bus(1'b0, 1'b1, 32'd0, 4'hF, ack, rd);
        total++; if (rd !== model_status(DEPTH, 1, 0)) begin bad++; $display("FAIL b2b_ovf_clr got=%h exp=%h", rd, model_status(DEPTH, 1, 0)); end
        wait_frames(base + DEPTH + 1, (DEPTH + 2) * (FRAME + 1) + 20);
        repeat (2 * FRAME) @(negedge clk);
        total++; if (rx_bits.size() !== base + DEPTH + 1) begin bad++; $display("FAIL b2b_frames got=%0d exp=%0d", rx_bits.size(), base + DEPTH + 1); end
        if (rx_bits.size() > base) begin
            total++; if (rx_t[base] !== c + 2) begin bad++; $display("FAIL b2b_start got=%0d exp=%0d", rx_t[base], c + 2); end
        end
        for (int i = 0; i <= DEPTH; i++) begin
            if (rx_bits.size() > base + i) begin
                total++; if (rx_bits[base + i] !== frame_of(b[i])) begin bad++; $display("FAIL b2b_bits%0d got=%b exp=%b", i, rx_bits[base + i], frame_of(b[i])); end
                if (i > 0) begin
                    total++; if (rx_t[base + i] - rx_t[base + i - 1] !== FRAME + 1) begin bad++; $display("FAIL b2b_period%0d got=%0d exp=%0d", i, rx_t[base + i] - rx_t[base + i - 1], FRAME + 1); end
                end
            end
        end
        bus(1'b0, 1'b1, 32'd0, 4'hF, ack, rd);
        total++; if (rd !== model_status(0, 0, 0)) begin bad++; $display("FAIL b2b_final got=%h exp=%h", rd, model_status(0, 0, 0)); end
    endtask

    task automatic test_ignored;
        logic ack;
        logic [31:0] rd;
        int base = rx_bits.size();
        bus(1'b1, 1'b0, 32'h0000_00FF, 4'hE, ack, rd);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL ign_sel_ack got=%b exp=1", ack); end
        bus(1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF, ack, rd);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL ign_stat_ack got=%b exp=1", ack); end
        bus(1'b0, 1'b1, 32'd0, 4'hF, ack, rd);
        total++; if (rd !== model_status(0, 0, 0)) begin bad++; $display("FAIL ign_status got=%h exp=%h", rd, model_status(0, 0, 0)); end
        repeat (FRAME + 20) @(negedge clk);
        total++; if (rx_bits.size() !== base) begin bad++; $display("FAIL ign_frames got=%0d exp=%0d", rx_bits.size(), base); end
        total++; if (o_uart_tx !== 1'b1) begin bad++; $display("FAIL ign_tx got=%b exp=1", o_uart_tx); end
    endtask

    task automatic test_random;
        logic ack;
        logic [31:0] rd;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int base = rx_bits.size();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            b = 8'($urandom);
            exp_q.push_back(b);
            bus(1'b1, 1'b0, {24'($urandom), b}, 4'h1 | 4'($urandom), ack, rd);
            total++; if (ack !== 1'b1) begin bad++; $display("FAIL rnd_ack%0d got=%b exp=1", i, ack); end
        end
        wait_frames(base + 4, 6 * (FRAME + 1));
        total++; if (rx_bits.size() !== base + 4) begin bad++; $display("FAIL rnd_frames got=%0d exp=%0d", rx_bits.size(), base + 4); end
        for (int i = 0; i < 4; i++) begin
            if (rx_bits.size() > base + i) begin
                total++; if (rx_bits[base + i] !== frame_of(exp_q[i])) begin bad++; $display("FAIL rnd_bits%0d got=%b exp=%b", i, rx_bits[base + i], frame_of(exp_q[i])); end
                if (i > 0) begin
                    total++; if (rx_t[base + i] - rx_t[base + i - 1] < FRAME + 1) begin bad++; $display("FAIL rnd_gap%0d got=%0d exp>=%0d", i, rx_t[base + i] - rx_t[base + i - 1], FRAME + 1); end
                end
            end
        end
        repeat (FRAME) @(negedge clk);
        bus(1'b0, 1'b1, 32'd0, 4'hF, ack, rd);
        total++; if (rd !== model_status(0, 0, 0)) begin bad++; $display("FAIL rnd_final got=%h exp=%h", rd, model_status(0, 0, 0)); end
    endtask

    task automatic test_reset_mid;
        logic ack;
        logic [31:0] rd;
        int base = rx_bits.size();
        int t0 = cyc + 2;
        bus(1'b1, 1'b0, {24'd0, 8'($urandom) & 8'hF7}, 4'h1, ack, rd);
        bus(1'b1, 1'b0, 32'($urandom), 4'h1, ack, rd);
        bus(1'b1, 1'b0, 32'($urandom), 4'h1, ack, rd);
        while (cyc < t0 + 4 + 3 * CPB) @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 30'd1;
        @(negedge clk);
        cyc_i = 1'b0; stb_i = 1'b0; addr_i = '0;
        total++; if (o_wb_ack !== 1'b1) begin bad++; $display("FAIL rm_pre_ack got=%b exp=1", o_wb_ack); end
        total++; if (o_wb_data !== model_status(2, 1, 0)) begin bad++; $display("FAIL rm_pre_status got=%h exp=%h", o_wb_data, model_status(2, 1, 0)); end
        total++; if (o_uart_tx !== 1'b0) begin bad++; $display("FAIL rm_pre_tx got=%b exp=0", o_uart_tx); end
        #1 rst = 1'b1;
        #1;
        total++; if (o_uart_tx !== 1'b1) begin bad++; $display("FAIL rm_async_tx got=%b exp=1", o_uart_tx); end
        total++; if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL rm_async_ack got=%b exp=0", o_wb_ack); end
        total++; if (o_wb_data !== 32'd0) begin bad++; $display("FAIL rm_async_data got=%h exp=0", o_wb_data); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus(1'b0, 1'b1, 32'd0, 4'hF, ack, rd);
        total++; if (rd !== model_status(0, 0, 0)) begin bad++; $display("FAIL rm_status got=%h exp=%h", rd, model_status(0, 0, 0)); end
        repeat (3 * FRAME) @(negedge clk);
        total++; if (rx_bits.size() !== base) begin bad++; $display("FAIL rm_frames got=%0d exp=%0d", rx_bits.size(), base); end
        total++; if (o_uart_tx !== 1'b1) begin bad++; $display("FAIL rm_tx got=%b exp=1", o_uart_tx); end
    endtask

    initial begin
        test_reset;
        test_frame_a5;
        test_b2b_reads;
        test_back_to_back;
        test_ignored;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
- Wishbone slave UART transmitter: 8N1, buffered by a FIFO.
- Sits downstream of the system bus address decode, alongside the other peripherals.
- The core writes bytes into the FIFO; a serialiser shifts them out on o_uart_tx at a fixed baud rate.
- The core polls a status word for FIFO level, busy and overflow.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2.
- LGFIFO, 4, log2 of FIFO depth; depth = 2**LGFIFO, legal range 1..7.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_wb_cyc  input  1  bus cycle.
- i_wb_stb  input  1  strobe, already qualified by the decode select.
- i_wb_we  input  1  write enable.
- i_wb_addr  input  30  word address; only bit 0 is decoded.
- i_wb_data  input  32  write data.
- i_wb_sel  input  4  byte selects.
- o_wb_ack  output  1  acknowledge.
- o_wb_stall  output  1  stall, tied 0.
- o_wb_data  output  32  read data.
- o_uart_tx  output  1  serial line, idle high.

Behaviour:
- Reset (async assert, released synchronously to i_clk):
  - o_wb_ack=0, o_wb_data=0, o_uart_tx=1.
  - FIFO emptied, overflow flag=0, FSM=IDLE, bit and baud counters=0.
  - Reset mid-frame aborts the frame immediately; the line returns high with no stop-bit completion.
- Bus handshake:
  - Request = i_wb_cyc && i_wb_stb.
  - o_wb_ack=1 exactly one cycle after each request and 0 otherwise; one ack per request, back-to-back requests allowed.
  - o_wb_stall is always 0.
- Register map (i_wb_addr[0]):
  - 0 = DATA.
    - Write with i_wb_sel[0]=1: push i_wb_data[7:0].
    - Write with i_wb_sel[0]=0: ignored, still acked.
    - Read returns 0.
  - 1 = STATUS (read-only; writes acked and ignored).
    - [7:0] FIFO count (0..2**LGFIFO, zero-extended).
    - [8] empty, [9] full.
    - [10] busy (FSM != IDLE).
    - [11] overflow (sticky).
    - [31:12]=0.
- o_wb_data:
  - Registered, valid in the ack cycle; STATUS reflects state at the request cycle.
  - 0 whenever o_wb_ack=0.
- FIFO:
  - Push accepted iff count < depth at the request cycle; a pop in the same cycle gives no credit.
  - Push to a full FIFO: byte dropped, overflow set.
  - STATUS read clears overflow in the ack cycle; a concurrent overflow event wins (flag stays 1).
  - Pointers wrap modulo depth; count is a separate LGFIFO+1-bit value.
  - Simultaneous push and pop on a non-full FIFO: count unchanged.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: o_uart_tx=1. If FIFO non-empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: o_uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_uart_tx=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit, shifting right. After bit 7, go to STOP.
  - STOP: o_uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - o_uart_tx is driven from a register (glitch-free).
- Timing:
  - Write request in cycle N to an empty FIFO with FSM idle: count=1 at N+1, pop at N+1, o_uart_tx falls at N+2.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames: the next start bit begins one IDLE cycle after STOP ends, so the period is 10*CLKS_PER_BIT+1.
- Arithmetic:
  - Baud counter width is clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps.

Test Plan:
- All tests use CLKS_PER_BIT=4, LGFIFO=2.
- Reset, then read STATUS -> ack 1 cycle later, data=0x100 (empty), o_uart_tx=1.
- Write 0xA5 to DATA with sel=0x1 -> o_uart_tx low 2 cycles after the request. Sampling at each bit midpoint gives 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); busy=1 during the frame, STATUS returns 0x100 after 40+ cycles.
- Write 6 bytes back-to-back while idle:
  - The first is popped immediately, 4 are buffered, the 6th is dropped.
  - STATUS read → 0xE04 (count=4, full, busy, overflow).
  - A second STATUS read returns the overflow bit cleared.
  - Exactly 5 frames are transmitted, each separated by one idle cycle.
- Write with sel=0xE, and write to STATUS -> both acked; no frame is sent and count stays 0.
- Assert i_reset during DATA bit 3 with 2 bytes queued -> o_uart_tx=1 and o_wb_ack=0 immediately without a clock edge; after release STATUS=0x100 and no further frames are sent.
- Read DATA and STATUS in consecutive cycles -> two acks in consecutive cycles; o_wb_data is 0 in the first ack cycle and the status value in the second; o_wb_stall stays 0 throughout.
